// File: rtl/systolic_link_host.sv
// Host-side end of the 4-beat nibble link to the systolic tile.
// TX serializes a column/row frame (16-bit word + 4-bit control each) into
// one nibble and one control bit per beat, MSB first. RX rebuilds the frame
// the tile sends back and presents it for one cycle on rx_valid.
module systolic_link_host #(
  parameter int WORD_W = 16,
  parameter int BEATS  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] tx_col_data,
  input  logic [BEATS-1:0]  tx_col_ctrl,
  input  logic [WORD_W-1:0] tx_row_data,
  input  logic [BEATS-1:0]  tx_row_ctrl,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [3:0]        col_nib_o,
  output logic [3:0]        row_nib_o,
  output logic              col_ctrl_o,
  output logic              row_ctrl_o,
  input  logic [3:0]        rx_col_nib,
  input  logic [3:0]        rx_row_nib,
  input  logic              rx_col_ctrl,
  input  logic              rx_row_ctrl,
  output logic [WORD_W-1:0] rx_col_data,
  output logic [BEATS-1:0]  rx_col_ctrl_o,
  output logic [WORD_W-1:0] rx_row_data,
  output logic [BEATS-1:0]  rx_row_ctrl_o,
  output logic              rx_valid,
  output logic              rx_is_result,
  output logic [1:0]        beat_o
);

  localparam int         NIB_W     = WORD_W / BEATS;
  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

  logic [1:0] beat_reg;
  logic [1:0] beat_next;
  logic       last_beat;

  assign beat_next = beat_reg + 2'd1;
  assign last_beat = (beat_reg == LAST_BEAT);

  // Free-running beat counter, in lockstep with the tile's own counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) beat_reg <= '0;
    else        beat_reg <= beat_next;
  end

  // ---------------------------------------------------------------- TX
  logic [WORD_W-1:0] frm_col_data_reg, frm_row_data_reg;
  logic [BEATS-1:0]  frm_col_ctrl_reg, frm_row_ctrl_reg;
  logic [WORD_W-1:0] launch_col_data, launch_row_data;
  logic [BEATS-1:0]  launch_col_ctrl, launch_row_ctrl;
  logic [WORD_W-1:0] col_data_shift, row_data_shift;
  logic [BEATS-1:0]  col_ctrl_shift, row_ctrl_shift;
  logic [3:0]        col_nib_reg, row_nib_reg, col_nib_next, row_nib_next;
  logic              col_ctrl_reg, row_ctrl_reg, col_ctrl_next, row_ctrl_next;

  // Pick the frame to launch (idle pass frame when nothing is offered) and
  // the nibble/bit that belongs to the next beat.
  always_comb begin
    launch_col_data = '0;
    launch_col_ctrl = '0;
    launch_row_data = '0;
    launch_row_ctrl = '0;
    if (tx_valid) begin
      launch_col_data = tx_col_data;
      launch_col_ctrl = tx_col_ctrl;
      launch_row_data = tx_row_data;
      launch_row_ctrl = tx_row_ctrl;
    end
    // Left-shifting by the next beat's offset brings its nibble to the top.
    col_data_shift = frm_col_data_reg << (NIB_W * int'(beat_next));
    row_data_shift = frm_row_data_reg << (NIB_W * int'(beat_next));
    col_ctrl_shift = frm_col_ctrl_reg << beat_next;
    row_ctrl_shift = frm_row_ctrl_reg << beat_next;
    if (last_beat) begin
      col_nib_next  = launch_col_data[WORD_W-1 -: NIB_W];
      row_nib_next  = launch_row_data[WORD_W-1 -: NIB_W];
      col_ctrl_next = launch_col_ctrl[BEATS-1];
      row_ctrl_next = launch_row_ctrl[BEATS-1];
    end else begin
      col_nib_next  = col_data_shift[WORD_W-1 -: NIB_W];
      row_nib_next  = row_data_shift[WORD_W-1 -: NIB_W];
      col_ctrl_next = col_ctrl_shift[BEATS-1];
      row_ctrl_next = row_ctrl_shift[BEATS-1];
    end
  end

  // Capture the frame at the beat-3 edge and register the pin outputs so
  // they only ever change at a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_col_data_reg <= '0;
      frm_col_ctrl_reg <= '0;
      frm_row_data_reg <= '0;
      frm_row_ctrl_reg <= '0;
      col_nib_reg      <= '0;
      row_nib_reg      <= '0;
      col_ctrl_reg     <= 1'b0;
      row_ctrl_reg     <= 1'b0;
    end else begin
      if (last_beat) begin
        frm_col_data_reg <= launch_col_data;
        frm_col_ctrl_reg <= launch_col_ctrl;
        frm_row_data_reg <= launch_row_data;
        frm_row_ctrl_reg <= launch_row_ctrl;
      end
      col_nib_reg  <= col_nib_next;
      row_nib_reg  <= row_nib_next;
      col_ctrl_reg <= col_ctrl_next;
      row_ctrl_reg <= row_ctrl_next;
    end
  end

  // ---------------------------------------------------------------- RX
  // Nibbles arrive MSB first, so shifting in from the bottom places beat b
  // at position b once the fourth nibble lands.
  logic [WORD_W-1:0] rx_col_asm_reg, rx_row_asm_reg, col_asm_next, row_asm_next;
  logic [BEATS-1:0]  rx_col_cb_reg, rx_row_cb_reg, col_cb_next, row_cb_next;
  logic [WORD_W-1:0] rx_col_data_reg, rx_row_data_reg;
  logic [BEATS-1:0]  rx_col_ctrl_reg, rx_row_ctrl_reg;
  logic              rx_valid_reg, rx_is_result_reg;
  logic              frame_is_result;

  assign col_asm_next = {rx_col_asm_reg[WORD_W-NIB_W-1:0], rx_col_nib};
  assign row_asm_next = {rx_row_asm_reg[WORD_W-NIB_W-1:0], rx_row_nib};
  assign col_cb_next  = {rx_col_cb_reg[BEATS-2:0], rx_col_ctrl};
  assign row_cb_next  = {rx_row_cb_reg[BEATS-2:0], rx_row_ctrl};
  // Address field [3:2] >= 2 is exactly "bit 3 set".
  assign frame_is_result = col_cb_next[BEATS-1] | row_cb_next[BEATS-1];

  // Assemble incoming beats and publish the completed frame after beat 3.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_col_asm_reg   <= '0;
      rx_row_asm_reg   <= '0;
      rx_col_cb_reg    <= '0;
      rx_row_cb_reg    <= '0;
      rx_col_data_reg  <= '0;
      rx_row_data_reg  <= '0;
      rx_col_ctrl_reg  <= '0;
      rx_row_ctrl_reg  <= '0;
      rx_valid_reg     <= 1'b0;
      rx_is_result_reg <= 1'b0;
    end else begin
      rx_col_asm_reg   <= col_asm_next;
      rx_row_asm_reg   <= row_asm_next;
      rx_col_cb_reg    <= col_cb_next;
      rx_row_cb_reg    <= row_cb_next;
      rx_valid_reg     <= last_beat;
      rx_is_result_reg <= last_beat & frame_is_result;
      if (last_beat) begin
        rx_col_data_reg <= col_asm_next;
        rx_row_data_reg <= row_asm_next;
        rx_col_ctrl_reg <= col_cb_next;
        rx_row_ctrl_reg <= row_cb_next;
      end
    end
  end

  assign tx_ready      = last_beat;
  assign col_nib_o     = col_nib_reg;
  assign row_nib_o     = row_nib_reg;
  assign col_ctrl_o    = col_ctrl_reg;
  assign row_ctrl_o    = row_ctrl_reg;
  assign rx_col_data   = rx_col_data_reg;
  assign rx_col_ctrl_o = rx_col_ctrl_reg;
  assign rx_row_data   = rx_row_data_reg;
  assign rx_row_ctrl_o = rx_row_ctrl_reg;
  assign rx_valid      = rx_valid_reg;
  assign rx_is_result  = rx_is_result_reg;
  assign beat_o        = beat_reg;

endmodule

// File: tb/tb_systolic_link_host.sv
// Loopback bench for systolic_link_host: TX pins feed the RX pins directly.
// A table of frames is sent back to back; every beat checks the serialized
// pins and every beat 0 checks the frame received from the previous period.
module tb_systolic_link_host;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] tx_col_data, tx_row_data;
  logic [3:0]  tx_col_ctrl, tx_row_ctrl;
  logic        tx_valid;
  logic        tx_ready;
  logic [3:0]  col_nib_o, row_nib_o;
  logic        col_ctrl_o, row_ctrl_o;
  logic [15:0] rx_col_data, rx_row_data;
  logic [3:0]  rx_col_ctrl_o, rx_row_ctrl_o;
  logic        rx_valid, rx_is_result;
  logic [1:0]  beat_o;

  always #5 clk = ~clk;

  systolic_link_host dut (
    .clk(clk), .rst_n(rst_n),
    .tx_col_data(tx_col_data), .tx_col_ctrl(tx_col_ctrl),
    .tx_row_data(tx_row_data), .tx_row_ctrl(tx_row_ctrl),
    .tx_valid(tx_valid), .tx_ready(tx_ready),
    .col_nib_o(col_nib_o), .row_nib_o(row_nib_o),
    .col_ctrl_o(col_ctrl_o), .row_ctrl_o(row_ctrl_o),
    .rx_col_nib(col_nib_o), .rx_row_nib(row_nib_o),
    .rx_col_ctrl(col_ctrl_o), .rx_row_ctrl(row_ctrl_o),
    .rx_col_data(rx_col_data), .rx_col_ctrl_o(rx_col_ctrl_o),
    .rx_row_data(rx_row_data), .rx_row_ctrl_o(rx_row_ctrl_o),
    .rx_valid(rx_valid), .rx_is_result(rx_is_result),
    .beat_o(beat_o)
  );

  // Inputs offered at the boundary, plus the hand-worked pin sequence
  // (nibbles beat 0..3 packed MSB first, ctrl bits beat 0..3 MSB first)
  // and the expected result flag of the received frame.
  typedef struct {
    logic [15:0] col_d;
    logic [3:0]  col_c;
    logic [15:0] row_d;
    logic [3:0]  row_c;
    logic        valid;
    logic [15:0] e_col_nib;
    logic [3:0]  e_col_cb;
    logic [15:0] e_row_nib;
    logic [3:0]  e_row_cb;
    logic        e_res;
  } vec_t;

  localparam int NV = 6;
  vec_t vecs [NV];
  vec_t idle_v;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_garbage;
    tx_col_data = 16'($urandom);
    tx_row_data = 16'($urandom);
    tx_col_ctrl = 4'($urandom);
    tx_row_ctrl = 4'($urandom);
    tx_valid    = 1'($urandom);
  endtask

  // Called at the negedge of a beat-3 cycle; returns at the next one.
  task automatic send_frame(input int idx, input vec_t v, input vec_t prev);
    tx_col_data = v.col_d;
    tx_col_ctrl = v.col_c;
    tx_row_data = v.row_d;
    tx_row_ctrl = v.row_c;
    tx_valid    = v.valid;
    tick();
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("f%0d beat b%0d", idx, b), 32'(beat_o), 32'(b));
      chk($sformatf("f%0d tx_ready b%0d", idx, b), 32'(tx_ready), 32'(b == 3));
      chk($sformatf("f%0d col_nib b%0d", idx, b), 32'(col_nib_o), 32'(v.e_col_nib[15-4*b -: 4]));
      chk($sformatf("f%0d row_nib b%0d", idx, b), 32'(row_nib_o), 32'(v.e_row_nib[15-4*b -: 4]));
      chk($sformatf("f%0d col_ctrl b%0d", idx, b), 32'(col_ctrl_o), 32'(v.e_col_cb[3-b]));
      chk($sformatf("f%0d row_ctrl b%0d", idx, b), 32'(row_ctrl_o), 32'(v.e_row_cb[3-b]));
      chk($sformatf("f%0d rx_valid b%0d", idx, b), 32'(rx_valid), 32'(b == 0));
      chk($sformatf("f%0d rx_is_result b%0d", idx, b), 32'(rx_is_result),
          32'((b == 0) ? prev.e_res : 1'b0));
      chk($sformatf("f%0d rx_col_data b%0d", idx, b), 32'(rx_col_data), 32'(prev.e_col_nib));
      chk($sformatf("f%0d rx_col_ctrl b%0d", idx, b), 32'(rx_col_ctrl_o), 32'(prev.e_col_cb));
      chk($sformatf("f%0d rx_row_data b%0d", idx, b), 32'(rx_row_data), 32'(prev.e_row_nib));
      chk($sformatf("f%0d rx_row_ctrl b%0d", idx, b), 32'(rx_row_ctrl_o), 32'(prev.e_row_cb));
      if (b < 3) begin
        drive_garbage();
        tick();
      end
    end
    $display("[TB] frame %0d sent col=%h/%h row=%h/%h valid=%0d; rx prev col=%h row=%h",
             idx, v.col_d, v.col_c, v.row_d, v.row_c, v.valid, rx_col_data, rx_row_data);
  endtask

  initial begin
    //          col_d     col_c  row_d     row_c  vld   e_col_nib e_col_cb e_row_nib e_row_cb res
    vecs[0] = '{16'hABCD, 4'h4, 16'h1234, 4'h8, 1'b1, 16'hABCD, 4'b0100, 16'h1234, 4'b1000, 1'b1};
    vecs[1] = '{16'hFFFF, 4'hF, 16'hEEEE, 4'hE, 1'b0, 16'h0000, 4'b0000, 16'h0000, 4'b0000, 1'b0};
    vecs[2] = '{16'h1111, 4'h1, 16'h5A5A, 4'h3, 1'b1, 16'h1111, 4'b0001, 16'h5A5A, 4'b0011, 1'b0};
    vecs[3] = '{16'h2222, 4'h8, 16'h0000, 4'h0, 1'b1, 16'h2222, 4'b1000, 16'h0000, 4'b0000, 1'b1};
    vecs[4] = '{16'h3333, 4'hC, 16'h9876, 4'h7, 1'b1, 16'h3333, 4'b1100, 16'h9876, 4'b0111, 1'b1};
    vecs[5] = '{16'h0000, 4'h0, 16'h0000, 4'h0, 1'b0, 16'h0000, 4'b0000, 16'h0000, 4'b0000, 1'b0};
    idle_v  = vecs[5];

    rst_n = 1'b0;
    tx_col_data = '0; tx_row_data = '0; tx_col_ctrl = '0; tx_row_ctrl = '0; tx_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset beat", 32'(beat_o), 32'd0);
    chk("reset col_nib", 32'(col_nib_o), 32'd0);
    chk("reset rx_col_data", 32'(rx_col_data), 32'd0);
    chk("reset rx_valid", 32'(rx_valid), 32'd0);

    // Release and watch the counter start from 0.
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rel beat k%0d", k), 32'(beat_o), 32'(k));
      chk($sformatf("rel tx_ready k%0d", k), 32'(tx_ready), 32'(k == 3));
      chk($sformatf("rel col_nib k%0d", k), 32'(col_nib_o), 32'd0);
      chk($sformatf("rel rx_valid k%0d", k), 32'(rx_valid), 32'd0);
      if (k < 3) tick();
    end

    // Table: back-to-back frames, rx of frame i checked during frame i+1.
    for (int i = 0; i < NV; i++) begin
      send_frame(i, vecs[i], (i == 0) ? idle_v : vecs[i-1]);
    end

    // Mid-frame reset: send ABCD then start 3333 and reset at its beat 2.
    send_frame(10, vecs[0], idle_v);
    tx_col_data = vecs[4].col_d; tx_col_ctrl = vecs[4].col_c;
    tx_row_data = vecs[4].row_d; tx_row_ctrl = vecs[4].row_c; tx_valid = 1'b1;
    tick();
    chk("pre-rst rx_col_data", 32'(rx_col_data), 32'h0000ABCD);
    tick();
    tick();
    chk("pre-rst beat", 32'(beat_o), 32'd2);
    chk("pre-rst col_nib", 32'(col_nib_o), 32'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst beat", 32'(beat_o), 32'd0);
    chk("async rst col_nib", 32'(col_nib_o), 32'd0);
    chk("async rst row_nib", 32'(row_nib_o), 32'd0);
    chk("async rst col_ctrl", 32'(col_ctrl_o), 32'd0);
    chk("async rst rx_col_data", 32'(rx_col_data), 32'd0);
    chk("async rst rx_col_ctrl", 32'(rx_col_ctrl_o), 32'd0);
    $display("[TB] reset asserted mid-frame at beat 2");
    tick();
    tick();
    chk("in rst rx_valid", 32'(rx_valid), 32'd0);
    tx_valid = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("post-rst beat k%0d", k), 32'(beat_o), 32'(k));
      chk($sformatf("post-rst rx_valid k%0d", k), 32'(rx_valid), 32'd0);
      chk($sformatf("post-rst col_nib k%0d", k), 32'(col_nib_o), 32'd0);
      if (k < 3) tick();
    end
    send_frame(11, vecs[0], idle_v);
    send_frame(12, idle_v, vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_link_host.md
Name: systolic_link_host

Overview:
- Host-side end of the 4-beat nibble link used by the systolic tile. Its transmitter serializes 16-bit column and row words, each with a 4-bit control field, into 4-bit nibbles plus 1 control bit per beat. Its receiver rebuilds the frames the tile sends back.
- Sits between the host or test controller and the tile pins: ui_in, uio_in[3:2], uo_out and uio_out[1:0].
- Keeps a beat counter in lockstep with the tile's counter, because both are released from reset together.

Parameters:
- WORD_W, 16, data bits per frame; must equal 4 * number of beats.
- BEATS, 4, beats per frame; fixed at 4, and the counter is 2 bits.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- tx_col_data  in  16  column word to send
- tx_col_ctrl  in  4  column control; [3:2] = address (0 pass, 1 A, 2 C0, 3 C2)
- tx_row_data  in  16  row word to send
- tx_row_ctrl  in  4  row control; [3:2] = address (0 pass, 1 B, 2 C1, 3 C3)
- tx_valid  in  1  frame offered
- tx_ready  out  1  frame accepted at this edge if tx_valid
- col_nib_o  out  4  to tile ui_in[7:4]
- row_nib_o  out  4  to tile ui_in[3:0]
- col_ctrl_o  out  1  to tile uio_in[3]
- row_ctrl_o  out  1  to tile uio_in[2]
- rx_col_nib  in  4  from tile uo_out[7:4]
- rx_row_nib  in  4  from tile uo_out[3:0]
- rx_col_ctrl  in  1  from tile uio_out[1]
- rx_row_ctrl  in  1  from tile uio_out[0]
- rx_col_data  out  16  received column word
- rx_col_ctrl_o  out  4  received column control
- rx_row_data  out  16  received row word
- rx_row_ctrl_o  out  4  received row control
- rx_valid  out  1  one-cycle pulse: new received frame
- rx_is_result  out  1  qualifies rx_valid: either received control [3:2] >= 2 (accumulator readout)
- beat_o  out  2  current beat

Behaviour:

Reset (rst_n low, asynchronous):
- beat = 0.
- All tx output registers = 0; tx frame register = 0 (an idle pass frame).
- All rx outputs = 0; rx assembly registers = 0.
- Reset asserted mid-frame abandons the frame: no rx_valid is produced for it, and the TX frame is dropped.
- After release, beat advances 0,1,2,3,0,... on every posedge and never stalls.

Beat and nibble order:
- Beat b carries data bits [15-4b : 12-4b] (MSB first) and control bit [3-b].

TX:
- tx_ready = (beat == 3), combinational from beat only.
- Frame accepted at the posedge ending beat 3 when tx_valid is high. It is transmitted during the following beats 0..3.
- If tx_valid is low at that edge, the idle frame is sent: data 0, ctrl 0.
- During the cycle with beat == b, col_nib_o, row_nib_o, col_ctrl_o and row_ctrl_o hold nibble/bit b of the current frame.
- These outputs are registered, updated only at posedge, and glitch-free.
- Back-to-back frames are allowed: accept every beat-3 edge with no gap.
- Inputs are sampled only at the accepting edge; changes to tx_* at other times have no effect.

RX:
- At the posedge ending beat b, sample the rx nibbles into position b and the ctrl bits into bit [3-b].
- At the posedge ending beat 3, transfer the complete frame, including that edge's nibble, to the rx_* output registers, and pulse rx_valid high for exactly the following cycle (beat 0).
- rx_is_result is valid only while rx_valid is high and is 0 otherwise.
- rx outputs hold until the next frame.
- There is no backpressure; the consumer must take each frame during its rx_valid cycle.

Simultaneous events:
- TX accept and RX completion occur on the same edge; they are independent.

Test Plan:
- Reset release: beat_o = 0,1,2,3,0 over the first 5 edges; all outputs 0; tx_ready high only while beat = 3.
- tx_col_data=0xABCD, ctrl=0x4, tx_row_data=0x1234, ctrl=0x8, valid at the first beat-3 edge -> col_nib_o A,B,C,D; col_ctrl_o 0,1,0,0; row_nib_o 1,2,3,4; row_ctrl_o 1,0,0,0 on beats 0..3.
- Loopback with tx outputs tied to rx inputs, frame as above -> rx_valid single pulse on the beat 0 after transmission; rx_col_data=0xABCD, rx_col_ctrl_o=0x4, rx_row_data=0x1234, rx_row_ctrl_o=0x8, rx_is_result=1.
- tx_valid low at a boundary -> all tx outputs 0 for the whole frame; loopback rx frame = 0/0 with rx_is_result=0.
- Three back-to-back frames 0x1111, 0x2222, 0x3333 -> contiguous nibbles with no idle beat; three rx_valid pulses exactly 4 cycles apart with matching data.
- rst_n asserted at beat 2 mid-frame -> outputs 0 immediately (asynchronous); no rx_valid pulse; after release the first accepted frame is received intact.
